// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider programming front-end:
// controller states, special ratio codes and the timeout terminal count.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int unsigned RATIO_STOP    = 0;
    localparam int unsigned RATIO_ILLEGAL = 1;

    // All-ones value of a (w+1)-bit counter, which outlasts the longest half period.
    function automatic int unsigned timeout_tc(input int unsigned w);
        return (32'd1 << (w + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/div_edge_det.sv
// One-flop edge detector on the divider's registered output clock.
// Both inputs share the controller's clock domain, so no synchroniser is needed.
module div_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic div_clk_fb,
    output logic fall,
    output logic rise
);

    logic fb_q;
    logic fb_d;

    always_comb begin
        fb_d = div_clk_fb;
    end

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_q <= 1'b0;
        end else begin
            fb_q <= fb_d;
        end
    end

    assign fall = fb_q & ~div_clk_fb;
    assign rise = ~fb_q & div_clk_fb;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Ratio-change front-end for the integer clock divider: accepts requests and
// applies them only on the cycle after the divided clock falls.
module div_ratio_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [width-1:0] req_ratio,
    output logic             req_ready,
    input  logic             div_clk_fb,
    output logic [width-1:0] div_ratio,
    output logic             div_enable,
    output logic             busy,
    output logic             err_pulse,
    output logic             timeout_pulse
);

    localparam int unsigned          TW    = width + 1;
    localparam int unsigned          TC_I  = timeout_tc(width);
    localparam logic [TW-1:0]        TC    = TC_I[TW-1:0];
    localparam logic [width-1:0]     R_STOP = width'(RATIO_STOP);
    localparam logic [width-1:0]     R_ILL  = width'(RATIO_ILLEGAL);

    state_e             state_q,   state_d;
    logic [width-1:0]   ratio_q,   ratio_d;
    logic               enable_q,  enable_d;
    logic [width-1:0]   pend_q,    pend_d;
    logic [TW-1:0]      tcnt_q,    tcnt_d;
    logic               err_q,     err_d;
    logic               tout_q,    tout_d;

    logic fall;
    logic unused_rise;
    logic accept;
    logic timeout;

    div_edge_det u_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .div_clk_fb (div_clk_fb),
        .fall       (fall),
        .rise       (unused_rise)
    );

    assign req_ready = (state_q != PEND);
    assign busy      = (state_q == PEND);
    assign accept    = req_valid && req_ready;
    assign timeout   = (state_q == PEND) && (tcnt_q == TC);

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        ratio_d  = ratio_q;
        enable_d = enable_q;
        pend_d   = pend_q;
        tcnt_d   = '0;
        err_d    = 1'b0;
        tout_d   = 1'b0;

        unique case (state_q)
            OFF: begin
                if (accept) begin
                    if (req_ratio == R_ILL) begin
                        err_d = 1'b1;
                    end else if (req_ratio != R_STOP) begin
                        // Divider is idle, so the new ratio can go straight out.
                        ratio_d  = req_ratio;
                        enable_d = 1'b1;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (req_ratio == R_ILL) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d  = req_ratio;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                tcnt_d = tcnt_q + TW'(1);
                if (fall || timeout) begin
                    tcnt_d = '0;
                    // A real fall wins over a coincident timeout.
                    tout_d = !fall;
                    if (pend_q == R_STOP) begin
                        enable_d = 1'b0;
                        state_d  = OFF;
                    end else begin
                        ratio_d = pend_q;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= OFF;
            ratio_q  <= '0;
            enable_q <= 1'b0;
            pend_q   <= '0;
            tcnt_q   <= '0;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ratio_q  <= ratio_d;
            enable_q <= enable_d;
            pend_q   <= pend_d;
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
            tout_q   <= tout_d;
        end
    end

    assign div_ratio     = ratio_q;
    assign div_enable    = enable_q;
    assign err_pulse     = err_q;
    assign timeout_pulse = tout_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed bench for div_ratio_ctrl: the divider feedback is driven by hand so
// every safe-point, error and timeout case lands on a known cycle.
module tb_div_ratio_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [W-1:0] req_ratio = '0;
    logic         div_clk_fb = 1'b0;
    logic         req_ready;
    logic [W-1:0] div_ratio;
    logic         div_enable;
    logic         busy;
    logic         err_pulse;
    logic         timeout_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    div_ratio_ctrl #(.width(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ratio     (req_ratio),
        .req_ready     (req_ready),
        .div_clk_fb    (div_clk_fb),
        .div_ratio     (div_ratio),
        .div_enable    (div_enable),
        .busy          (busy),
        .err_pulse     (err_pulse),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int ratio, input bit en,
                              input bit bsy, input bit rdy, input bit err, input bit tout);
        check({tag, ".div_ratio"},     32'(div_ratio),     32'(ratio));
        check({tag, ".div_enable"},    32'(div_enable),    32'(en));
        check({tag, ".busy"},          32'(busy),          32'(bsy));
        check({tag, ".req_ready"},     32'(req_ready),     32'(rdy));
        check({tag, ".err_pulse"},     32'(err_pulse),     32'(err));
        check({tag, ".timeout_pulse"}, 32'(timeout_pulse), 32'(tout));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;

        // Reset state
        #12;
        check_outs("reset", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // OFF -> RUN with ratio 4, one-edge latency
        req_valid = 1'b1;
        req_ratio = 8'd4;
        check("off_ready_before", 32'(req_ready), 32'd1);
        tick();
        check_outs("off_req4", 4, 1, 0, 1, 0, 0);
        req_valid = 1'b0;

        // RUN 4 -> 6, applied the edge after the feedback falls
        div_clk_fb = 1'b1;
        tick();
        req_valid = 1'b1;
        req_ratio = 8'd6;
        tick();
        req_valid = 1'b0;
        check_outs("pend6", 4, 1, 1, 0, 0, 0);
        tick();
        tick();
        check_outs("pend6_hold", 4, 1, 1, 0, 0, 0);
        div_clk_fb = 1'b0;
        tick();
        check_outs("apply6", 6, 1, 0, 1, 0, 0);
        tick();
        check_outs("apply6_after", 6, 1, 0, 1, 0, 0);

        // Move to ratio 5, then request stop
        div_clk_fb = 1'b1;
        req_valid  = 1'b1;
        req_ratio  = 8'd5;
        tick();
        req_valid  = 1'b0;
        div_clk_fb = 1'b0;
        tick();
        check_outs("apply5", 5, 1, 0, 1, 0, 0);
        req_valid = 1'b1;
        req_ratio = 8'd0;
        tick();
        req_valid = 1'b0;
        check_outs("pend0", 5, 1, 1, 0, 0, 0);
        div_clk_fb = 1'b1;
        tick();
        check_outs("pend0_high", 5, 1, 1, 0, 0, 0);
        div_clk_fb = 1'b0;
        tick();
        check_outs("stop", 5, 0, 0, 1, 0, 0);

        // Illegal and stop requests while OFF, then start at 3 and an illegal in RUN
        req_valid = 1'b1;
        req_ratio = 8'd1;
        tick();
        check_outs("err_off", 5, 0, 0, 1, 1, 0);
        req_ratio = 8'd0;
        tick();
        check_outs("zero_off", 5, 0, 0, 1, 0, 0);
        req_ratio = 8'd3;
        tick();
        check_outs("off_req3", 3, 1, 0, 1, 0, 0);
        req_ratio = 8'd1;
        tick();
        check_outs("err_run", 3, 1, 0, 1, 1, 0);
        req_valid = 1'b0;
        tick();
        check_outs("err_run_end", 3, 1, 0, 1, 0, 0);

        // Broken feedback: request 7 times out; a held request for 2 is stalled, not lost
        req_valid = 1'b1;
        req_ratio = 8'd7;
        tick();
        req_ratio = 8'd2;
        bad = 0;
        for (int i = 0; i < 511; i++) begin
            if (req_ready !== 1'b0 || busy !== 1'b1 || timeout_pulse !== 1'b0 || div_ratio !== 8'd3)
                bad++;
            tick();
        end
        check("stall_511_cycles", 32'(bad), 32'd0);
        check_outs("pend7_last", 3, 1, 1, 0, 0, 0);
        tick();
        check_outs("tout_apply", 7, 1, 0, 1, 0, 1);
        tick();
        req_valid = 1'b0;
        check_outs("stalled_req", 7, 1, 1, 0, 0, 0);

        // Fall and timeout on the same cycle count as a fall
        div_clk_fb = 1'b1;
        bad = 0;
        for (int i = 0; i < 511; i++) begin
            if (busy !== 1'b1 || timeout_pulse !== 1'b0) bad++;
            tick();
        end
        check("simul_wait", 32'(bad), 32'd0);
        div_clk_fb = 1'b0;
        tick();
        check_outs("simul_apply", 2, 1, 0, 1, 0, 0);
        tick();
        check_outs("simul_after", 2, 1, 0, 1, 0, 0);

        // Reset while pending 9: request discarded
        req_valid = 1'b1;
        req_ratio = 8'd9;
        tick();
        req_valid = 1'b0;
        check_outs("pend9", 2, 1, 1, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("mid_reset", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            div_clk_fb = 1'b1;
            tick();
            div_clk_fb = 1'b0;
            tick();
        end
        check_outs("after_reset", 0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
